// File: rtl/stream_stego_pipe.sv
// AXI-Stream LSB steganography pipe: embeds message bits into selected colour
// channels, carries beats through a fixed-latency pipeline into an FWFT FIFO.
module stream_stego_pipe #(
    parameter int NUM_CH          = 3,
    parameter int PIXELS_PER_LINE = 1920,
    parameter int LAT             = 2,
    parameter int DEPTH           = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_mode,
    input  logic [NUM_CH-1:0]     cfg_ch_mask,
    input  logic [NUM_CH*8-1:0]   s00_axis_tdata,
    input  logic                  s00_axis_tvalid,
    input  logic                  s00_axis_tlast,
    input  logic                  s00_axis_tuser,
    output logic                  s00_axis_tready,
    input  logic [7:0]            msg_tdata,
    input  logic                  msg_tvalid,
    output logic                  msg_tready,
    output logic [NUM_CH*8-1:0]   m00_axis_tdata,
    output logic                  m00_axis_tvalid,
    output logic                  m00_axis_tlast,
    output logic                  m00_axis_tuser,
    input  logic                  m00_axis_tready,
    output logic [31:0]           bits_embedded,
    output logic                  line_err
);

    localparam int DW  = NUM_CH * 8;
    localparam int BW  = DW + 2;
    localparam int MCW = $clog2(9);
    localparam int IFW = $clog2(LAT + 1);
    localparam int FCW = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam int PCW = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1;
    localparam logic [PCW-1:0] PIX_LAST = PCW'(PIXELS_PER_LINE - 1);

    logic [7:0]      msg_sr_r;
    logic [MCW-1:0]  msg_cnt_r;
    logic [LAT-1:0]  vld_r;
    logic [BW-1:0]   stg_r [LAT];
    logic [BW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [FCW-1:0]  fifo_cnt_r;
    logic [IFW-1:0]  inflight_r;
    logic [PCW-1:0]  pix_cnt_r;
    logic [31:0]     bits_r;
    logic            line_err_r;

    logic            accept_s;
    logic            pop_s;
    logic            consume_s;
    logic            msg_load_s;
    logic            fifo_wr_s;
    logic [31:0]     occ_s;
    logic [DW-1:0]   embed_data_s;
    logic [BW-1:0]   head_s;

    // Occupancy counts beats already committed downstream, so the FIFO can never overflow.
    assign occ_s      = 32'(fifo_cnt_r) + 32'(inflight_r);
    assign s00_axis_tready = ~reset & (occ_s < 32'(DEPTH)) & (~cfg_mode | (msg_cnt_r != '0));
    assign msg_tready = ~reset & ((msg_cnt_r == '0) |
                                  ((msg_cnt_r == MCW'(1)) & accept_s & cfg_mode));

    assign accept_s   = s00_axis_tvalid & s00_axis_tready;
    assign pop_s      = m00_axis_tvalid & m00_axis_tready;
    assign consume_s  = accept_s & cfg_mode;
    assign msg_load_s = msg_tvalid & msg_tready;
    assign fifo_wr_s  = vld_r[LAT-1];

    assign head_s          = mem_r[rd_ptr_r];
    assign m00_axis_tdata  = head_s[DW-1:0];
    assign m00_axis_tlast  = head_s[DW];
    assign m00_axis_tuser  = head_s[DW+1];
    assign m00_axis_tvalid = ~reset & (fifo_cnt_r != '0);
    assign bits_embedded   = bits_r;
    assign line_err        = line_err_r & ~reset;

    // Replace bit 0 of each enabled channel with the current message bit.
    always_comb begin
        embed_data_s = s00_axis_tdata;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_mode && cfg_ch_mask[c]) begin
                embed_data_s[8*c] = msg_sr_r[0];
            end else begin
                embed_data_s[8*c] = s00_axis_tdata[8*c];
            end
        end
    end

    // Message byte register; a refill on the last-bit cycle takes priority over the shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_sr_r  <= '0;
            msg_cnt_r <= '0;
        end else if (msg_load_s) begin
            msg_sr_r  <= msg_tdata;
            msg_cnt_r <= MCW'(8);
        end else if (consume_s) begin
            msg_sr_r  <= {1'b0, msg_sr_r[7:1]};
            msg_cnt_r <= msg_cnt_r - MCW'(1);
        end
    end

    // Non-stalling pipeline valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_r <= '0;
        end else begin
            vld_r[0] <= accept_s;
            for (int i = 1; i < LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
            end
        end
    end

    // Pipeline payload; qualified by vld_r so it needs no reset.
    always_ff @(posedge clk) begin
        stg_r[0] <= {s00_axis_tuser, s00_axis_tlast, embed_data_s};
        for (int i = 1; i < LAT; i++) begin
            stg_r[i] <= stg_r[i-1];
        end
    end

    // Beats accepted but not yet written into the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_r <= '0;
        end else begin
            case ({accept_s, fifo_wr_s})
                2'b10:   inflight_r <= inflight_r + IFW'(1);
                2'b01:   inflight_r <= inflight_r - IFW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            mem_r[wr_ptr_r] <= stg_r[LAT-1];
        end
    end

    // FIFO pointers and fill level; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (fifo_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({fifo_wr_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + FCW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - FCW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Output line-length tracking; a mismatch between tlast and the pixel count is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt_r  <= '0;
            line_err_r <= 1'b0;
        end else if (pop_s) begin
            if (m00_axis_tlast || (pix_cnt_r == PIX_LAST)) begin
                pix_cnt_r <= '0;
            end else begin
                pix_cnt_r <= pix_cnt_r + PCW'(1);
            end
            if (m00_axis_tlast != (pix_cnt_r == PIX_LAST)) begin
                line_err_r <= 1'b1;
            end
        end
    end

    // Saturating count of consumed message bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            bits_r <= '0;
        end else if (consume_s && (bits_r != '1)) begin
            bits_r <= bits_r + 32'd1;
        end
    end

endmodule

// File: tb/tb_stream_stego_pipe.sv
// Self-checking bench for stream_stego_pipe: directed scenarios plus a random
// phase, all checked against a queue-based behavioural model every cycle.
module tb_stream_stego_pipe;

    localparam int NUM_CH = 3;
    localparam int PPL    = 4;
    localparam int LAT    = 2;
    localparam int DEPTH  = 16;
    localparam int DW     = NUM_CH * 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_mode = 1'b0;
    logic [NUM_CH-1:0] cfg_ch_mask = '0;
    logic [DW-1:0]     s00_axis_tdata = '0;
    logic              s00_axis_tvalid = 1'b0;
    logic              s00_axis_tlast = 1'b0;
    logic              s00_axis_tuser = 1'b0;
    logic              s00_axis_tready;
    logic [7:0]        msg_tdata = '0;
    logic              msg_tvalid = 1'b0;
    logic              msg_tready;
    logic [DW-1:0]     m00_axis_tdata;
    logic              m00_axis_tvalid;
    logic              m00_axis_tlast;
    logic              m00_axis_tuser;
    logic              m00_axis_tready = 1'b1;
    logic [31:0]       bits_embedded;
    logic              line_err;

    stream_stego_pipe #(
        .NUM_CH(NUM_CH), .PIXELS_PER_LINE(PPL), .LAT(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .cfg_ch_mask(cfg_ch_mask),
        .s00_axis_tdata(s00_axis_tdata), .s00_axis_tvalid(s00_axis_tvalid),
        .s00_axis_tlast(s00_axis_tlast), .s00_axis_tuser(s00_axis_tuser),
        .s00_axis_tready(s00_axis_tready),
        .msg_tdata(msg_tdata), .msg_tvalid(msg_tvalid), .msg_tready(msg_tready),
        .m00_axis_tdata(m00_axis_tdata), .m00_axis_tvalid(m00_axis_tvalid),
        .m00_axis_tlast(m00_axis_tlast), .m00_axis_tuser(m00_axis_tuser),
        .m00_axis_tready(m00_axis_tready),
        .bits_embedded(bits_embedded), .line_err(line_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW+1:0] beat;
        int            due;
    } exp_t;

    exp_t          expq[$];
    bit            msgq[$];
    logic [DW-1:0] popped[$];
    logic [31:0]   exp_bits = '0;
    int            exp_pix = 0;
    logic          exp_lerr = 1'b0;
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            n_acc = 0;
    int            n_pop = 0;
    bit            acc_now, msg_now, pop_now;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: compare DUT against the model at the falling edge, then
    // apply the handshakes that the coming rising edge will perform.
    task automatic tick();
        logic [DW-1:0] d;
        bit            b;
        exp_t          e;
        @(negedge clk);
        cyc++;
        acc_now = s00_axis_tvalid && s00_axis_tready;
        msg_now = msg_tvalid && msg_tready;
        pop_now = m00_axis_tvalid && m00_axis_tready;
        if (reset) begin
            check("rst_s_tready", s00_axis_tready, 0);
            check("rst_msg_tready", msg_tready, 0);
            check("rst_m_tvalid", m00_axis_tvalid, 0);
            check("rst_line_err", line_err, 0);
            check("rst_bits", bits_embedded, exp_bits);
            expq.delete();
            msgq.delete();
            exp_bits = '0;
            exp_pix  = 0;
            exp_lerr = 1'b0;
            acc_now = 0; msg_now = 0; pop_now = 0;
        end else begin
            check("s_tready", s00_axis_tready,
                  (expq.size() < DEPTH) && (!cfg_mode || msgq.size() != 0));
            check("msg_tready", msg_tready,
                  (msgq.size() == 0) || (msgq.size() == 1 && acc_now && cfg_mode));
            check("m_tvalid", m00_axis_tvalid, (expq.size() != 0) && (expq[0].due <= cyc));
            check("bits_embedded", bits_embedded, exp_bits);
            check("line_err", line_err, exp_lerr);
            if (pop_now) begin
                if (expq.size() == 0) begin
                    check("pop_when_model_empty", m00_axis_tvalid, 0);
                end else begin
                    check("out_beat", {m00_axis_tuser, m00_axis_tlast, m00_axis_tdata}, expq[0].beat);
                    if (m00_axis_tlast != (exp_pix == PPL - 1)) exp_lerr = 1'b1;
                    exp_pix = (m00_axis_tlast || exp_pix == PPL - 1) ? 0 : exp_pix + 1;
                    popped.push_back(m00_axis_tdata);
                    void'(expq.pop_front());
                    n_pop++;
                end
            end
            if (acc_now) begin
                d = s00_axis_tdata;
                if (cfg_mode) begin
                    b = 1'b0;
                    if (msgq.size() == 0) check("msg_bit_avail", s00_axis_tready, 0);
                    else b = msgq.pop_front();
                    for (int c = 0; c < NUM_CH; c++) if (cfg_ch_mask[c]) d[8*c] = b;
                    if (exp_bits != 32'hFFFF_FFFF) exp_bits = exp_bits + 32'd1;
                end
                e.beat = {s00_axis_tuser, s00_axis_tlast, d};
                e.due  = cyc + LAT + 1;
                expq.push_back(e);
                n_acc++;
            end
            if (msg_now) for (int i = 0; i < 8; i++) msgq.push_back(msg_tdata[i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l, input logic u);
        s00_axis_tdata  = d;
        s00_axis_tlast  = l;
        s00_axis_tuser  = u;
        s00_axis_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (acc_now) break;
        end
        check("send_accept", acc_now, 1);
    endtask

    task automatic send_msg(input logic [7:0] m);
        msg_tdata  = m;
        msg_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (msg_now) break;
        end
        check("msg_accept", msg_now, 1);
        msg_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s00_axis_tvalid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic rst_pulse();
        s00_axis_tvalid = 1'b0;
        msg_tvalid      = 1'b0;
        reset           = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int c0, a0, p0, lpos;
        repeat (3) tick();
        reset = 1'b0;

        // Bypass: data unchanged, no bits consumed.
        cfg_mode = 1'b0;
        popped.delete();
        send(24'hA1B2C3, 1'b0, 1'b1);
        send(24'h000001, 1'b0, 1'b0);
        idle(6);
        check("bypass_count", popped.size(), 2);
        check("bypass_px0", popped[0], 24'hA1B2C3);
        check("bypass_px1", popped[1], 24'h000001);
        check("bypass_bits", bits_embedded, 32'd0);

        // Embed 0x05 into channels 0 and 2 of eight 0xFEFEFE pixels.
        cfg_mode    = 1'b1;
        cfg_ch_mask = 3'b101;
        send_msg(8'h05);
        popped.delete();
        for (int i = 0; i < 8; i++) send(24'hFEFEFE, i == 7, i == 0);
        idle(6);
        check("embed_count", popped.size(), 8);
        for (int i = 0; i < 8; i++)
            check("embed_px", popped[i], (i == 0 || i == 2) ? 24'hFFFEFF : 24'hFEFEFE);
        check("embed_bits", bits_embedded, 32'd8);
        check("starved_tready", s00_axis_tready, 0);

        // Refill on the last-bit accept cycle: no bubble.
        send_msg(8'hC3);
        for (int i = 0; i < 7; i++) send(DW'($urandom), 1'b0, 1'b0);
        msg_tdata  = 8'h3C;
        msg_tvalid = 1'b1;
        send(DW'($urandom), 1'b0, 1'b0);
        check("refill_same_cycle", msg_now, 1);
        msg_tvalid = 1'b0;
        c0 = cyc;
        send(DW'($urandom), 1'b0, 1'b0);
        check("refill_no_bubble", cyc - c0, 1);
        for (int i = 0; i < 7; i++) send(DW'($urandom), 1'b0, 1'b0);
        idle(6);
        check("refill_starved", s00_axis_tready, 0);

        // Random traffic with correct line framing.
        rst_pulse();
        lpos = 0;
        for (int i = 0; i < 1500; i++) begin
            cfg_mode        = ($urandom_range(0, 3) != 0);
            cfg_ch_mask     = NUM_CH'($urandom);
            s00_axis_tvalid = ($urandom_range(0, 9) < 7);
            s00_axis_tdata  = DW'($urandom);
            s00_axis_tlast  = (lpos == PPL - 1);
            s00_axis_tuser  = (lpos == 0);
            m00_axis_tready = ($urandom_range(0, 9) < 7);
            msg_tvalid      = $urandom_range(0, 1);
            msg_tdata       = 8'($urandom);
            tick();
            if (acc_now) lpos = (lpos == PPL - 1) ? 0 : lpos + 1;
        end
        msg_tvalid      = 1'b0;
        cfg_mode        = 1'b0;
        m00_axis_tready = 1'b1;
        idle(40);
        check("random_drained", m00_axis_tvalid, 0);

        // Backpressure: FIFO holds exactly DEPTH beats, then drains in order.
        rst_pulse();
        cfg_mode        = 1'b0;
        m00_axis_tready = 1'b0;
        a0 = n_acc;
        s00_axis_tvalid = 1'b1;
        s00_axis_tlast  = 1'b0;
        s00_axis_tuser  = 1'b0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            s00_axis_tdata = DW'($urandom);
            tick();
        end
        check("bp_accepted", n_acc - a0, DEPTH);
        check("bp_tready", s00_axis_tready, 0);
        popped.delete();
        m00_axis_tready = 1'b1;
        idle(DEPTH + 8);
        check("bp_drained", popped.size(), DEPTH);

        // Line check: short line sets a sticky error; correct lines after reset do not.
        rst_pulse();
        for (int i = 0; i < 3; i++) send(DW'($urandom), i == 2, i == 0);
        idle(6);
        check("short_line_err", line_err, 1);
        for (int i = 0; i < 4; i++) send(DW'($urandom), i == 3, i == 0);
        idle(6);
        check("line_err_sticky", line_err, 1);
        rst_pulse();
        for (int i = 0; i < 8; i++) send(DW'($urandom), (i % 4) == 3, (i % 4) == 0);
        idle(6);
        check("good_lines_err", line_err, 0);

        // Mid-stream reset with five beats buffered and two in flight.
        cfg_mode        = 1'b1;
        cfg_ch_mask     = 3'b111;
        m00_axis_tready = 1'b0;
        send_msg(8'hA5);
        for (int i = 0; i < 7; i++) send(DW'($urandom), 1'b0, 1'b0);
        s00_axis_tvalid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_tvalid", m00_axis_tvalid, 0);
        check("midrst_bits", bits_embedded, 32'd0);
        m00_axis_tready = 1'b1;
        p0 = n_pop;
        idle(12);
        check("midrst_no_stale", n_pop - p0, 0);
        check("midrst_msg_tready", msg_tready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_stego_pipe.md
STREAM_STEGO_PIPE -- requirements
Module: stream_stego_pipe

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: 8-bit colour channels per pixel.
REQ-002 SHALL have parameter PIXELS_PER_LINE, default 1920: expected beats per tlast-terminated line.
REQ-003 SHALL have parameter LAT, default 2 (legal range 1..8): embed pipeline stages.
REQ-004 SHALL have parameter DEPTH, default 512 (power of 2, at least 4): output FIFO entries.
REQ-005 SHALL have the following ports, in this order:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- cfg_mode  in  1  0 = bypass, 1 = embed.
- cfg_ch_mask  in  NUM_CH  per-channel embed enable.
- s00_axis_tdata  in  NUM_CH*8  input pixel; channel c at bits [8c+7:8c].
- s00_axis_tvalid, s00_axis_tlast, s00_axis_tuser  in  1 each.
- s00_axis_tready  out  1.
- msg_tdata  in  8  message byte.
- msg_tvalid  in  1.
- msg_tready  out  1.
- m00_axis_tdata  out  NUM_CH*8.
- m00_axis_tvalid, m00_axis_tlast, m00_axis_tuser  out  1 each.
- m00_axis_tready  in  1.
- bits_embedded  out  32  count of message bits consumed.
- line_err  out  1  sticky line-length error flag.

Function
REQ-006 SHALL define accept = s00_axis_tvalid & s00_axis_tready, and pop = m00_axis_tvalid & m00_axis_tready.
REQ-007 SHALL hold a message shift register (8 bits) and a bit count msg_cnt (0..8).
- msg_tready = (msg_cnt==0) | (msg_cnt==1 & accept & cfg_mode).
- msg_tvalid & msg_tready loads the byte and sets msg_cnt to 8.
REQ-008 SHALL consume message bits LSB first: one bit per accept when cfg_mode=1, decrementing msg_cnt.
- A bit is consumed even when cfg_ch_mask is all zero.
- No bit is consumed when cfg_mode=0.
REQ-009 SHALL drive s00_axis_tready = (fifo_cnt + inflight < DEPTH) & (cfg_mode==0 | msg_cnt!=0), combinationally.
REQ-010 SHALL form each output channel c as follows:
- if cfg_mode & cfg_ch_mask[c]: input channel c with bit 0 replaced by the current message bit;
- otherwise: input channel c unchanged.
- cfg_mode and cfg_ch_mask are sampled at the accept cycle only; later changes do not affect in-flight beats.
REQ-011 SHALL carry tlast and tuser alongside the data through exactly LAT register stages, each with a valid bit.
- The stages never stall.
- The last stage writes {tuser, tlast, tdata} into the FIFO.
REQ-012 SHALL maintain inflight (0..LAT): +1 on accept, -1 on FIFO write, unchanged when both occur in the same cycle.
REQ-013 SHALL implement the FIFO as first-word-fall-through with fifo_cnt (0..DEPTH).
- m00_axis_tvalid = fifo_cnt != 0.
- m00_axis_tdata, tlast and tuser come from the FIFO head.
- Simultaneous write and pop leave fifo_cnt unchanged.
- Overflow is impossible by REQ-009; an empty FIFO is never popped.
REQ-014 SHALL count popped beats in pix_cnt (0..PIXELS_PER_LINE-1).
- A pop with tlast, or a pop at pix_cnt==PIXELS_PER_LINE-1, returns pix_cnt to 0.
- Every other pop increments pix_cnt.
REQ-015 SHALL set line_err on either of these pops:
- a tlast pop with pix_cnt != PIXELS_PER_LINE-1;
- a pop at pix_cnt == PIXELS_PER_LINE-1 without tlast.
- line_err is cleared only by reset.
REQ-016 SHALL increment bits_embedded per consumed message bit, saturating at 0xFFFFFFFF.
REQ-017 SHALL give 8-bit channel arithmetic no carry between channels; all counters SHALL be sized with clog2 of their maximum value + 1.
REQ-018 SHALL produce data on m00_axis LAT+1 cycles after accept when the FIFO is empty and m00_axis_tready=1 (LAT stages plus 1 FIFO write cycle).

Reset
REQ-019 SHALL, while reset=1 at a clk edge, clear all of the following:
- msg_cnt, inflight, fifo_cnt, pix_cnt, all pipeline valid bits, bits_embedded, line_err.
REQ-020 SHALL hold s00_axis_tready, msg_tready, m00_axis_tvalid and line_err at 0 while reset is high; msg_tready returns to 1 on the first cycle after reset.
REQ-021 SHALL discard in-flight and buffered beats, and any partially used message byte, when reset is asserted mid-stream.

Verification
REQ-022 Bypass: cfg_mode=0, feed 0xA1B2C3 and 0x000001 -> identical outputs in order, latency LAT+1, bits_embedded=0, msg_tready stays 1.
REQ-023 Embed: cfg_mode=1, mask=3'b101, msg byte 0x05, 8 pixels of 0xFEFEFE -> per-pixel bits 1,0,1,0,0,0,0,0 in channels 0 and 2 only; first pixel 0xFFFEFF; bits_embedded=8.
REQ-024 Message starvation: cfg_mode=1, msg_tvalid=0 after one byte -> s00_axis_tready drops after 8 accepts; a new byte presented on the 8th accept cycle is taken with no bubble.
REQ-025 Backpressure: m00_axis_tready=0 with continuous input -> exactly DEPTH beats buffered, s00_axis_tready=0, no loss; release -> all beats drain in order.
REQ-026 Line check: PIXELS_PER_LINE=4, tlast on the 3rd beat -> line_err=1 and stays 1; correct 4-beat lines after reset -> line_err=0.
REQ-027 Mid-stream reset: reset asserted with fifo_cnt=5 and inflight=2 -> next cycle m00_axis_tvalid=0 and bits_embedded=0; no stale beats emerge afterwards.
